// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction codes, default packet field positions,
// FSM state encoding for the input-port routing unit, and the XY route
// function used by every router flavour.
package noc_pkg;

  // Direction codes; also the index into the per-output full/req vectors.
  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_E  = 3'd1;
  localparam logic [2:0] DIR_S  = 3'd2;
  localparam logic [2:0] DIR_W  = 3'd3;
  localparam logic [2:0] DIR_PE = 3'd4;

  // Default packet layout.
  localparam int DEF_PKT_W     = 64;
  localparam int DEF_HOP_W     = 2;
  localparam int DEF_DIR_X_BIT = 58;
  localparam int DEF_DIR_Y_BIT = 57;
  localparam int DEF_HOP_X_LSB = 55;
  localparam int DEF_HOP_Y_LSB = 53;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } ru_state_e;

  // X-first routing: exhaust X hops, then Y hops, then deliver locally.
  function automatic logic [2:0] xy_route(input logic hop_x_nz,
                                          input logic hop_y_nz,
                                          input logic dir_x,
                                          input logic dir_y);
    logic [2:0] dir_s;
    if (hop_x_nz) begin
      dir_s = dir_x ? DIR_W : DIR_E;
    end else if (hop_y_nz) begin
      dir_s = dir_y ? DIR_S : DIR_N;
    end else begin
      dir_s = DIR_PE;
    end
    return dir_s;
  endfunction

endpackage

// File: rtl/routing_unit.sv
// Input-port routing unit: pops the port FIFO, registers an XY route and a
// hop-decremented copy of the packet, requests one output arbiter, drops
// U-turn packets and flags long stalls.
module routing_unit
  import noc_pkg::*;
#(
  parameter int PKT_W     = DEF_PKT_W,
  parameter int HOP_W     = DEF_HOP_W,
  parameter int IN_DIR    = 2,
  parameter int DIR_X_BIT = DEF_DIR_X_BIT,
  parameter int DIR_Y_BIT = DEF_DIR_Y_BIT,
  parameter int HOP_X_LSB = DEF_HOP_X_LSB,
  parameter int HOP_Y_LSB = DEF_HOP_Y_LSB,
  parameter int STALL_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               empty,
  input  logic [PKT_W-1:0]   in_packet,
  output logic               read_en,
  input  logic [4:0]         full,
  output logic [5*PKT_W-1:0] out_packet,
  output logic [4:0]         out_req,
  output logic               err_uturn,
  output logic [7:0]         err_count,
  output logic               stall_alarm
);

  localparam int              STALL_W     = $clog2(STALL_MAX + 1);
  localparam logic [STALL_W-1:0] STALL_MAX_C = STALL_W'(STALL_MAX);
  localparam logic [2:0]      IN_DIR_C    = 3'(IN_DIR);
  localparam logic            IS_PE_PORT  = (IN_DIR == 4);
  localparam logic [HOP_W-1:0] HOP_ONE    = {{(HOP_W-1){1'b0}}, 1'b1};

  ru_state_e          state_r, state_nxt_s;
  logic [PKT_W-1:0]   pkt_r;
  logic [2:0]         rt_dir_r;
  logic [STALL_W-1:0] stall_cnt_r;
  logic               err_uturn_r;
  logic [7:0]         err_count_r;

  logic               hold_s, full_sel_s, drop_s, xfer_s, discard_s, done_s, pop_s;
  logic [HOP_W-1:0]   hop_x_s, hop_y_s;
  logic [2:0]         route_s;
  logic [PKT_W-1:0]   pkt_cap_s;
  logic               uturn_cap_s;

  // Route decision and hop decrement for the FIFO head word.
  always_comb begin
    hop_x_s   = in_packet[HOP_X_LSB +: HOP_W];
    hop_y_s   = in_packet[HOP_Y_LSB +: HOP_W];
    route_s   = xy_route(|hop_x_s, |hop_y_s, in_packet[DIR_X_BIT], in_packet[DIR_Y_BIT]);
    pkt_cap_s = in_packet;
    case (route_s)
      DIR_E, DIR_W: pkt_cap_s[HOP_X_LSB +: HOP_W] = hop_x_s - HOP_ONE;
      DIR_N, DIR_S: pkt_cap_s[HOP_Y_LSB +: HOP_W] = hop_y_s - HOP_ONE;
      default:      pkt_cap_s = in_packet;
    endcase
    uturn_cap_s = (route_s == IN_DIR_C) && !IS_PE_PORT;
  end

  // Transfer / discard / pop decisions for the held packet.
  always_comb begin
    hold_s = (state_r == ST_HOLD);
    case (rt_dir_r)
      DIR_N:   full_sel_s = full[0];
      DIR_E:   full_sel_s = full[1];
      DIR_S:   full_sel_s = full[2];
      DIR_W:   full_sel_s = full[3];
      DIR_PE:  full_sel_s = full[4];
      default: full_sel_s = 1'b1;
    endcase
    drop_s    = hold_s && (rt_dir_r == IN_DIR_C) && !IS_PE_PORT;
    xfer_s    = hold_s && !full_sel_s && !drop_s;
    discard_s = hold_s && drop_s;
    done_s    = xfer_s || discard_s;
    pop_s     = reset && !empty && (!hold_s || done_s);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a pop always leaves a packet held; completion without a pop empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: state_nxt_s = pop_s ? ST_HOLD : ST_EMPTY;
      ST_HOLD: begin
        if (done_s) begin
          state_nxt_s = pop_s ? ST_HOLD : ST_EMPTY;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Outputs: one-hot request, replicated lanes (zero when empty), FIFO pop.
  always_comb begin
    read_en = pop_s;
    if (xfer_s) begin
      out_req = 5'b00001 << rt_dir_r;
    end else begin
      out_req = 5'b00000;
    end
    if (hold_s) begin
      out_packet = {5{pkt_r}};
    end else begin
      out_packet = '0;
    end
    err_uturn   = err_uturn_r;
    err_count   = err_count_r;
    stall_alarm = (stall_cnt_r == STALL_MAX_C);
  end

  // Capture packet and route on pop; the U-turn flag covers the discard cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_r       <= '0;
      rt_dir_r    <= 3'd0;
      err_uturn_r <= 1'b0;
    end else begin
      err_uturn_r <= pop_s && uturn_cap_s;
      if (pop_s) begin
        pkt_r    <= pkt_cap_s;
        rt_dir_r <= route_s;
      end else begin
        pkt_r    <= pkt_r;
        rt_dir_r <= rt_dir_r;
      end
    end
  end

  // Saturating drop counter and blocked-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_r <= 8'd0;
      stall_cnt_r <= '0;
    end else begin
      if (discard_s && (err_count_r != 8'd255)) begin
        err_count_r <= err_count_r + 8'd1;
      end else begin
        err_count_r <= err_count_r;
      end
      if (hold_s && !drop_s && full_sel_s) begin
        if (stall_cnt_r != STALL_MAX_C) begin
          stall_cnt_r <= stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
          stall_cnt_r <= stall_cnt_r;
        end
      end else begin
        stall_cnt_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_routing_unit.sv
// Directed bench for routing_unit instantiated as the south input port.
module tb_routing_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         empty;
  logic [63:0]  in_packet;
  logic         read_en;
  logic [4:0]   full;
  logic [319:0] out_packet;
  logic [4:0]   out_req;
  logic         err_uturn;
  logic [7:0]   err_count;
  logic         stall_alarm;

  int tests = 0;
  int fails = 0;
  int exp_errs = 0;

  routing_unit #(.PKT_W(64), .HOP_W(2), .IN_DIR(2), .DIR_X_BIT(58), .DIR_Y_BIT(57),
                 .HOP_X_LSB(55), .HOP_Y_LSB(53), .STALL_MAX(15)) dut (
    .clk(clk), .reset(reset), .empty(empty), .in_packet(in_packet), .read_en(read_en),
    .full(full), .out_packet(out_packet), .out_req(out_req), .err_uturn(err_uturn),
    .err_count(err_count), .stall_alarm(stall_alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] hx, input logic [1:0] hy,
                                     input logic dx, input logic dy, input logic [31:0] pay);
    logic [63:0] p;
    p = {32'h0000_0000, pay};
    p[63:59] = 5'h15;
    p[58] = dx;
    p[57] = dy;
    p[56:55] = hx;
    p[54:53] = hy;
    return p;
  endfunction

  function automatic logic [63:0] lane(input int d);
    return out_packet[d*64 +: 64];
  endfunction

  typedef struct {
    logic [63:0] pkt;
    logic [4:0]  fl;
    logic [4:0]  req;
    logic [63:0] exp_pkt;
    int          ln;
    logic        uturn;
  } vec_t;

  vec_t vecs[8];
  logic [63:0] b2b_pkt[4];
  logic [63:0] b2b_exp[4];
  logic [4:0]  b2b_req[4];
  int          b2b_ln[4];

  initial begin
    vecs[0] = '{mk(2'd2, 2'd0, 1'b0, 1'b0, 32'hA1), 5'b00000, 5'b00010, mk(2'd1, 2'd0, 1'b0, 1'b0, 32'hA1), 1, 1'b0};
    vecs[1] = '{mk(2'd1, 2'd0, 1'b1, 1'b0, 32'hB2), 5'b00000, 5'b01000, mk(2'd0, 2'd0, 1'b1, 1'b0, 32'hB2), 3, 1'b0};
    vecs[2] = '{mk(2'd0, 2'd1, 1'b0, 1'b0, 32'hC3), 5'b00000, 5'b00001, mk(2'd0, 2'd0, 1'b0, 1'b0, 32'hC3), 0, 1'b0};
    vecs[3] = '{mk(2'd0, 2'd0, 1'b1, 1'b1, 32'hD4), 5'b00000, 5'b10000, mk(2'd0, 2'd0, 1'b1, 1'b1, 32'hD4), 4, 1'b0};
    vecs[4] = '{mk(2'd0, 2'd3, 1'b0, 1'b1, 32'hE5), 5'b00000, 5'b00000, mk(2'd0, 2'd2, 1'b0, 1'b1, 32'hE5), 2, 1'b1};
    vecs[5] = '{mk(2'd3, 2'd2, 1'b0, 1'b1, 32'hF6), 5'b00000, 5'b00010, mk(2'd2, 2'd2, 1'b0, 1'b1, 32'hF6), 1, 1'b0};
    vecs[6] = '{mk(2'd1, 2'd0, 1'b0, 1'b0, 32'h07), 5'b11101, 5'b00010, mk(2'd0, 2'd0, 1'b0, 1'b0, 32'h07), 1, 1'b0};
    vecs[7] = '{mk(2'd0, 2'd1, 1'b1, 1'b1, 32'h88), 5'b00000, 5'b00000, mk(2'd0, 2'd0, 1'b1, 1'b1, 32'h88), 2, 1'b1};

    b2b_pkt[0] = mk(2'd1, 2'd0, 1'b0, 1'b0, 32'h100); b2b_exp[0] = mk(2'd0, 2'd0, 1'b0, 1'b0, 32'h100);
    b2b_req[0] = 5'b00010; b2b_ln[0] = 1;
    b2b_pkt[1] = mk(2'd0, 2'd2, 1'b0, 1'b0, 32'h101); b2b_exp[1] = mk(2'd0, 2'd1, 1'b0, 1'b0, 32'h101);
    b2b_req[1] = 5'b00001; b2b_ln[1] = 0;
    b2b_pkt[2] = mk(2'd2, 2'd0, 1'b1, 1'b0, 32'h102); b2b_exp[2] = mk(2'd1, 2'd0, 1'b1, 1'b0, 32'h102);
    b2b_req[2] = 5'b01000; b2b_ln[2] = 3;
    b2b_pkt[3] = mk(2'd0, 2'd0, 1'b0, 1'b0, 32'h103); b2b_exp[3] = mk(2'd0, 2'd0, 1'b0, 1'b0, 32'h103);
    b2b_req[3] = 5'b10000; b2b_ln[3] = 4;

    // Reset state, with a word waiting so read_en gating is visible.
    reset = 1'b0; empty = 1'b0; full = 5'b00000; in_packet = mk(2'd1, 2'd0, 1'b0, 1'b0, 32'h55);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_read_en", 64'(read_en), 64'd0);
    chk("rst_out_req", 64'(out_req), 64'd0);
    chk("rst_out_packet", 64'(|out_packet), 64'd0);
    chk("rst_err_uturn", 64'(err_uturn), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_stall_alarm", 64'(stall_alarm), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1; empty = 1'b1;

    // Single-packet table: pop, observe request cycle, observe return to empty.
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      in_packet = vecs[v].pkt; empty = 1'b0; full = vecs[v].fl;
      #2 chk($sformatf("v%0d_read_en", v), 64'(read_en), 64'd1);
      @(posedge clk); #1;
      empty = 1'b1;
      #2;
      chk($sformatf("v%0d_out_req", v), 64'(out_req), 64'(vecs[v].req));
      chk($sformatf("v%0d_lane", v), lane(vecs[v].ln), vecs[v].exp_pkt);
      chk($sformatf("v%0d_err_uturn", v), 64'(err_uturn), 64'(vecs[v].uturn));
      @(posedge clk); #1;
      if (vecs[v].uturn) exp_errs++;
      #2;
      chk($sformatf("v%0d_req_idle", v), 64'(out_req), 64'd0);
      chk($sformatf("v%0d_lanes_zero", v), 64'(|out_packet), 64'd0);
      chk($sformatf("v%0d_err_count", v), 64'(err_count), 64'(exp_errs));
      chk($sformatf("v%0d_uturn_clear", v), 64'(err_uturn), 64'd0);
    end

    // U-turn discard with the next word popped in the discard cycle.
    @(posedge clk); #1;
    full = 5'b00000; in_packet = mk(2'd0, 2'd1, 1'b0, 1'b1, 32'hAA); empty = 1'b0;
    @(posedge clk); #1;
    in_packet = mk(2'd2, 2'd0, 1'b0, 1'b0, 32'hBB);
    #2;
    chk("ut_read_en", 64'(read_en), 64'd1);
    chk("ut_out_req", 64'(out_req), 64'd0);
    chk("ut_err_uturn", 64'(err_uturn), 64'd1);
    @(posedge clk); #1;
    empty = 1'b1; exp_errs++;
    #2;
    chk("ut_next_req", 64'(out_req), 64'b00010);
    chk("ut_next_lane", lane(1), mk(2'd1, 2'd0, 1'b0, 1'b0, 32'hBB));
    chk("ut_err_count", 64'(err_count), 64'(exp_errs));
    chk("ut_uturn_clear", 64'(err_uturn), 64'd0);
    @(posedge clk); #3;
    chk("ut_idle", 64'(out_req), 64'd0);

    // Stall: east target full for 20 cycles with another word waiting.
    @(posedge clk); #1;
    in_packet = mk(2'd1, 2'd0, 1'b0, 1'b0, 32'hCC); empty = 1'b0; full = 5'b00010;
    @(posedge clk); #1;
    in_packet = mk(2'd0, 2'd0, 1'b0, 1'b0, 32'hDD);
    for (int i = 0; i < 20; i++) begin
      #2;
      chk($sformatf("st%0d_read_en", i), 64'(read_en), 64'd0);
      chk($sformatf("st%0d_out_req", i), 64'(out_req), 64'd0);
      chk($sformatf("st%0d_alarm", i), 64'(stall_alarm), 64'(i >= 15));
      @(posedge clk); #1;
    end
    full = 5'b00000;
    #2;
    chk("st_release_req", 64'(out_req), 64'b00010);
    chk("st_release_read_en", 64'(read_en), 64'd1);
    chk("st_release_alarm", 64'(stall_alarm), 64'd1);
    @(posedge clk); #1;
    empty = 1'b1;
    #2;
    chk("st_alarm_clear", 64'(stall_alarm), 64'd0);
    chk("st_next_req", 64'(out_req), 64'b10000);
    chk("st_next_lane", lane(4), mk(2'd0, 2'd0, 1'b0, 1'b0, 32'hDD));
    @(posedge clk); #3;
    chk("st_idle", 64'(out_req), 64'd0);

    // Back-to-back: four words, one transfer per cycle.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      in_packet = b2b_pkt[i]; empty = 1'b0;
      #2;
      chk($sformatf("bb%0d_read_en", i), 64'(read_en), 64'd1);
      if (i > 0) begin
        chk($sformatf("bb%0d_req", i - 1), 64'(out_req), 64'(b2b_req[i-1]));
        chk($sformatf("bb%0d_lane", i - 1), lane(b2b_ln[i-1]), b2b_exp[i-1]);
      end
      @(posedge clk); #1;
    end
    empty = 1'b1;
    #2;
    chk("bb3_req", 64'(out_req), 64'(b2b_req[3]));
    chk("bb3_lane", lane(b2b_ln[3]), b2b_exp[3]);
    chk("bb_read_en_off", 64'(read_en), 64'd0);
    @(posedge clk); #3;
    chk("bb_idle", 64'(out_req), 64'd0);

    // Asynchronous reset while holding a packet whose request is live.
    @(posedge clk); #1;
    in_packet = mk(2'd1, 2'd0, 1'b0, 1'b0, 32'hEE); empty = 1'b0; full = 5'b00010;
    @(posedge clk); #1;
    full = 5'b00000;
    #1;
    chk("ar_pre_req", 64'(out_req), 64'b00010);
    chk("ar_pre_read_en", 64'(read_en), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_out_req", 64'(out_req), 64'd0);
    chk("ar_read_en", 64'(read_en), 64'd0);
    chk("ar_lanes", 64'(|out_packet), 64'd0);
    chk("ar_err_count", 64'(err_count), 64'd0);
    chk("ar_alarm", 64'(stall_alarm), 64'd0);
    exp_errs = 0;
    @(posedge clk); #1;
    reset = 1'b1; empty = 1'b1;
    @(posedge clk); #1;
    in_packet = mk(2'd0, 2'd2, 1'b0, 1'b0, 32'hFF); empty = 1'b0;
    #2 chk("ar_post_read_en", 64'(read_en), 64'd1);
    @(posedge clk); #1;
    empty = 1'b1;
    #2;
    chk("ar_post_req", 64'(out_req), 64'b00001);
    chk("ar_post_lane", lane(0), mk(2'd0, 2'd1, 1'b0, 1'b0, 32'hFF));
    @(posedge clk); #3;
    chk("ar_post_idle", 64'(out_req), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
